// File: rtl/result_drain_serializer.sv
// Captures the N x N result matrix of a systolic array on a completion edge and
// drains it one element per beat over a valid/ready stream, row- or column-major.
module result_drain_serializer #(
  parameter int BW    = 16,
  parameter int N     = 5,
  parameter int RES_W = N * 2 * BW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RES_W-1:0]     iRes [0:N-1][0:N-1],
  input  logic                 iFinished,
  input  logic                 iColMajor,
  input  logic                 iReady,
  output logic                 oValid,
  output logic [RES_W-1:0]     oData,
  output logic [$clog2(N)-1:0] oRow,
  output logic [$clog2(N)-1:0] oCol,
  output logic                 oLast,
  output logic                 oBusy,
  output logic                 oDone,
  output logic                 oOverrun
);

  localparam int IW = $clog2(N);
  localparam int KW = $clog2(N * N);
  localparam logic [IW-1:0] MAX_IDX   = IW'(N - 1);
  localparam logic [KW-1:0] LAST_BEAT = KW'(N * N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_r;
  logic            finPrev_r;
  logic            colMajor_r;
  logic [KW-1:0]   beat_r;
  logic [RES_W-1:0] snap_r [0:N-1][0:N-1];

  logic            finEdge_s;
  logic            xfer_s;
  logic [IW-1:0]   nextRow_s;
  logic [IW-1:0]   nextCol_s;

  assign finEdge_s = iFinished & ~finPrev_r;
  assign xfer_s    = oValid & iReady;

  // Matrix position of the beat after the one currently presented.
  always_comb begin
    nextRow_s = oRow;
    nextCol_s = oCol;
    if (colMajor_r) begin
      if (oRow == MAX_IDX) begin
        nextRow_s = IW'(0);
        nextCol_s = oCol + IW'(1);
      end else begin
        nextRow_s = oRow + IW'(1);
      end
    end else begin
      if (oCol == MAX_IDX) begin
        nextCol_s = IW'(0);
        nextRow_s = oRow + IW'(1);
      end else begin
        nextCol_s = oCol + IW'(1);
      end
    end
  end

  // Snapshot of the result matrix, taken only on an accepted completion edge.
  always_ff @(posedge clk) begin
    if (!rst && state_r == IDLE && finEdge_s) begin
      snap_r <= iRes;
    end
  end

  // Drain FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      finPrev_r  <= 1'b0;
      colMajor_r <= 1'b0;
      beat_r     <= '0;
      oValid     <= 1'b0;
      oData      <= '0;
      oRow       <= '0;
      oCol       <= '0;
      oLast      <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oOverrun   <= 1'b0;
    end else begin
      finPrev_r <= iFinished;
      case (state_r)
        IDLE: begin
          oDone <= 1'b0;
          if (finEdge_s) begin
            // First beat is served straight from the inputs being captured.
            state_r    <= STREAM;
            colMajor_r <= iColMajor;
            beat_r     <= '0;
            oValid     <= 1'b1;
            oBusy      <= 1'b1;
            oRow       <= IW'(0);
            oCol       <= IW'(0);
            oData      <= iRes[0][0];
            oLast      <= (LAST_BEAT == KW'(0));
          end
        end
        STREAM: begin
          if (finEdge_s) begin
            oOverrun <= 1'b1;
          end
          if (xfer_s) begin
            if (beat_r == LAST_BEAT) begin
              state_r <= DONE;
              oValid  <= 1'b0;
              oLast   <= 1'b0;
              oDone   <= 1'b1;
            end else begin
              beat_r <= beat_r + KW'(1);
              oRow   <= nextRow_s;
              oCol   <= nextCol_s;
              oData  <= snap_r[nextRow_s][nextCol_s];
              oLast  <= ((beat_r + KW'(1)) == LAST_BEAT);
            end
          end
        end
        DONE: begin
          if (finEdge_s) begin
            oOverrun <= 1'b1;
          end
          state_r <= IDLE;
          oDone   <= 1'b0;
          oBusy   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          oValid  <= 1'b0;
          oLast   <= 1'b0;
          oDone   <= 1'b0;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
